multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Control unit for the multicycle MIPS datapath. It runs a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback. Inputs are op, funct and zero from the datapath. It drives every datapath select and enable, plus memwrite to the unified instruction/data memory.

Parameters:
STATE_W, 4, width of the encoded state / debug port

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
op  input  6  instr[31:26] from datapath IR
funct  input  6  instr[5:0] from datapath IR
zero  input  1  ALU zero flag (combinational, current cycle)
pcen  output  1  PC register enable
irwrite  output  1  instruction register enable
regwrite  output  1  register file write enable
memwrite  output  1  memory write strobe
alusrca  output  1  0=pc, 1=A register
iord  output  1  0=pc address, 1=aluout address
memtoreg  output  1  0=aluout, 1=data register to regfile
regdst  output  1  0=rt, 1=rd as write register
alusrcb  output  2  00=B, 01=const 4, 10=signimm, 11=signimm<<2
pcsrc  output  2  00=aluresult, 01=aluout, 10=jump target
alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
state  output  STATE_W  current FSM state, for debug/bench

Behaviour:
- Reset behaviour (fixed decision): one clock; reset is synchronous and active-high. A clk edge with reset=1 sets state=FETCH.
- While reset=1, pcen, irwrite, regwrite and memwrite are forced to 0. Other outputs show their FETCH values. Reset mid-instruction abandons the instruction with no further writes.
- All outputs are combinational from state, plus op/funct/zero where noted. Every output not listed for a state is 0.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- aluop is internal: 00 add, 01 sub, 10 decode by funct.
  - funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown funct gives 010 (add).
- pcen = pcwrite | (branch & zero).

States, outputs and transitions:
- FETCH(0): iord=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1. Next: DECODE.
- DECODE(1): alusrca=0, alusrcb=11, aluop=00 (precomputes the branch target into aluout). Next state by op:
  - lw/sw -> MEMADR
  - R -> RTYPEEX
  - beq -> BEQEX
  - addi -> ADDIEX
  - j -> JEX
  - any other op -> FETCH (treated as nop; PC has already advanced).
- MEMADR(2): alusrca=1, alusrcb=10, aluop=00. Next: MEMRD if op=lw, MEMWR if op=sw.
- MEMRD(3): iord=1. Next: MEMWB.
- MEMWB(4): regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
- MEMWR(5): iord=1, memwrite=1. Next: FETCH.
- RTYPEEX(6): alusrca=1, alusrcb=00, aluop=10. Next: RTYPEWB.
- RTYPEWB(7): regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
- BEQEX(8): alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next: FETCH.
- ADDIEX(9): alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
- ADDIWB(10): regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
- JEX(11): pcsrc=10, pcwrite=1. Next: FETCH.
- Unused encodings 12-15 go to FETCH with all enables 0.

Latency in cycles: lw 5, sw 4, R 4, addi 4, beq 3, j 3, unknown op 2.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct localparams
  - alucontrol codes
  - aluop codes
  - state_t enum (4-bit, encodings as above)
- One sub-module, aludec (aluop, funct -> alucontrol), purely combinational.
- The FSM and output decode live in multicycle_controller.

Test Plan:
- Reset: reset=1 for 2 edges -> state=0; pcen=irwrite=regwrite=memwrite=0 while reset=1. First cycle after release: pcen=1, irwrite=1, alusrcb=01, alucontrol=010.
- lw: op=100011 -> states 0,1,2,3,4,0.
  - state 2: alusrcb=10.
  - state 3: iord=1.
  - state 4: regwrite=1, memtoreg=1, regdst=0.
  - memwrite=0 throughout.
- sw then R-type:
  - op=101011 -> memwrite=1 and iord=1 only in state 5.
  - op=0, funct=101010 -> alucontrol=111 in state 6; regwrite=1, regdst=1 in state 7.
- beq: op=000100, zero=1 in state 8 -> pcen=1, pcsrc=01, alucontrol=110. Repeat with zero=0 -> pcen=0.
- j and illegal op:
  - op=000010 -> state 11 with pcen=1, pcsrc=10.
  - op=111111 -> DECODE then FETCH, with no regwrite/memwrite asserted.
- Reset mid-instruction: assert reset in state 3 (lw) -> next edge state=0; MEMWB never entered; regwrite stays 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the opcode and funct encodings, ALU control codes, the internal
// aluop codes and the FSM state enumeration.
package mips_ctrl_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // R-type funct field (instr[5:0])
  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  // ALU control codes driven to the datapath
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  // Internal ALU operation class chosen by the FSM
  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } aluop_t;

  // FSM states; encodings are visible on the debug port
  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJEx     = 4'd11
  } state_t;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the FSM's aluop class and the instruction funct field
// to the 3-bit ALU control code. Purely combinational.
//   aluop_i      : operation class from the FSM
//   funct_i      : instr[5:0]
//   alucontrol_o : ALU control code
module aludec
  import mips_ctrl_pkg::*;
(
  input  aluop_t     aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = AluAdd;
    case (aluop_i)
      AluOpAdd: alucontrol_o = AluAdd;
      AluOpSub: alucontrol_o = AluSub;
      AluOpFunct: begin
        case (funct_i)
          FunctAdd: alucontrol_o = AluAdd;
          FunctSub: alucontrol_o = AluSub;
          FunctAnd: alucontrol_o = AluAnd;
          FunctOr:  alucontrol_o = AluOr;
          FunctSlt: alucontrol_o = AluSlt;
          default:  alucontrol_o = AluAdd;  // unknown funct behaves as add
        endcase
      end
      default: alucontrol_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback and drives
// every datapath select and enable.
//   clk, reset       : clock, synchronous active-high reset
//   op, funct, zero  : IR fields and ALU zero flag from the datapath
//   pcen ... memwrite: datapath enables (forced low while reset=1)
//   alusrca ... pcsrc: datapath selects
//   alucontrol       : ALU operation
//   state            : current FSM state for debug
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcen,
  output logic               irwrite,
  output logic               regwrite,
  output logic               memwrite,
  output logic               alusrca,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic [STATE_W-1:0] state
);

  state_t state_q;
  state_t dec_state;
  aluop_t aluop;
  logic   pcwrite, branch, irwrite_raw, regwrite_raw, memwrite_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch:  state_q <= StDecode;
        StDecode: begin
          case (op)
            OpLw, OpSw: state_q <= StMemAdr;
            OpRtype:    state_q <= StRtypeEx;
            OpBeq:      state_q <= StBeqEx;
            OpAddi:     state_q <= StAddiEx;
            OpJ:        state_q <= StJEx;
            default:    state_q <= StFetch;  // unknown op: PC already advanced
          endcase
        end
        StMemAdr: begin
          if (op == OpLw)      state_q <= StMemRd;
          else if (op == OpSw) state_q <= StMemWr;
          else                 state_q <= StFetch;
        end
        StMemRd:   state_q <= StMemWb;
        StRtypeEx: state_q <= StRtypeWb;
        StAddiEx:  state_q <= StAddiWb;
        default:   state_q <= StFetch;
      endcase
    end
  end

  // During reset the selects show FETCH values regardless of the held state.
  assign dec_state = reset ? StFetch : state_q;

  always_comb begin
    pcwrite      = 1'b0;
    branch       = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    alusrca      = 1'b0;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = AluOpAdd;
    case (dec_state)
      StFetch: begin
        alusrcb     = 2'b01;
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
      end
      StDecode: alusrcb = 2'b11;  // branch target precomputed into aluout
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: iord = 1'b1;
      StMemWb: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      StMemWr: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      StRtypeEx: begin
        alusrca = 1'b1;
        aluop   = AluOpFunct;
      end
      StRtypeWb: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      StBeqEx: begin
        alusrca = 1'b1;
        aluop   = AluOpSub;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StAddiWb: regwrite_raw = 1'b1;
      StJEx: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen     = ~reset & (pcwrite | (branch & zero));
  assign irwrite  = ~reset & irwrite_raw;
  assign regwrite = ~reset & regwrite_raw;
  assign memwrite = ~reset & memwrite_raw;
  assign state    = STATE_W'(state_q);

  aludec u_aludec (
    .aluop_i     (aluop),
    .funct_i     (funct),
    .alucontrol_o(alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios with literal
// expectations, then randomized instruction streams checked every cycle
// against an instruction-level model (state path per opcode + output table).
module tb_multicycle_controller;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  logic       clk = 1'b0;
  logic       reset, zero;
  logic [5:0] op, funct;
  logic       pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int m_pos   = 0;  // cycle index within the current instruction
  bit check_en = 1'b0;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .pcen      (pcen),
    .irwrite   (irwrite),
    .regwrite  (regwrite),
    .memwrite  (memwrite),
    .alusrca   (alusrca),
    .iord      (iord),
    .memtoreg  (memtoreg),
    .regdst    (regdst),
    .alusrcb   (alusrcb),
    .pcsrc     (pcsrc),
    .alucontrol(alucontrol),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Instruction length in cycles.
  function automatic int seq_len(input logic [5:0] o);
    case (o)
      LW:             return 5;
      SW, R, ADDI:    return 4;
      BEQ, JMP:       return 3;
      default:        return 2;
    endcase
  endfunction

  // State visited at cycle p of an instruction with opcode o.
  function automatic int seq_state(input logic [5:0] o, input int p);
    if (p == 0) return 0;
    if (p == 1) return 1;
    case (o)
      LW:      return (p == 2) ? 2 : (p == 3) ? 3 : 4;
      SW:      return (p == 2) ? 2 : 5;
      R:       return (p == 2) ? 6 : 7;
      ADDI:    return (p == 2) ? 9 : 10;
      BEQ:     return 8;
      JMP:     return 11;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // {pcen,irwrite,regwrite,memwrite,alusrca,iord,memtoreg,regdst,alusrcb,pcsrc,alucontrol}
  function automatic logic [14:0] exp_vec(input int st_in, input logic [5:0] f,
                                          input logic z, input logic rst);
    int st;
    logic pw, br, irw, rw, mw, asa, io, mtr, rd, pe;
    logic [1:0] asb, ps;
    logic [2:0] alc;
    st = rst ? 0 : st_in;
    {pw, br, irw, rw, mw, asa, io, mtr, rd} = '0;
    asb = 2'b00; ps = 2'b00; alc = 3'b010;
    case (st)
      0:  begin asb = 2'b01; irw = 1; pw = 1; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  io = 1;
      4:  begin mtr = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin asa = 1; alc = funct_alu(f); end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; alc = 3'b110; ps = 2'b01; br = 1; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pw = 1; end
      default: ;
    endcase
    pe = pw | (br & z);
    if (rst) {pe, irw, rw, mw} = '0;
    return {pe, irw, rw, mw, asa, io, mtr, rd, asb, ps, alc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model advance.
  always @(posedge clk) begin
    if (reset) m_pos <= 0;
    else if (m_pos + 1 >= seq_len(op)) m_pos <= 0;
    else m_pos <= m_pos + 1;
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("state", {28'd0, state}, seq_state(op, m_pos));
      check("outputs",
            {17'd0, pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst,
             alusrcb, pcsrc, alucontrol},
            {17'd0, exp_vec(seq_state(op, m_pos), funct, zero, reset)});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; op = R; funct = 6'b100000; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    at_neg;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_enables", {28'd0, pcen, irwrite, regwrite, memwrite}, 32'd0);
    tick;  // reset edge again, then release
    reset = 1'b0;
    at_neg;
    check("post_rst_fetch", {23'd0, pcen, irwrite, alusrcb, alucontrol},
          {23'd0, 1'b1, 1'b1, 2'b01, 3'b010});

    // lw
    op = LW;
    tick; tick;
    at_neg; check("lw_memadr", {28'd0, state, alusrcb[1:0] == 2'b10}, {28'd0, 4'd2, 1'b1});
    tick;
    at_neg; check("lw_memrd_iord", {27'd0, state, iord}, {27'd0, 4'd3, 1'b1});
    tick;
    at_neg; check("lw_memwb", {25'd0, state, regwrite, memtoreg, regdst},
                  {25'd0, 4'd4, 1'b1, 1'b1, 1'b0});
    tick;
    at_neg; check("lw_done", {28'd0, state}, 32'd0);

    // sw
    op = SW;
    tick; tick; tick;
    at_neg; check("sw_memwr", {26'd0, state, memwrite, iord}, {26'd0, 4'd5, 1'b1, 1'b1});
    tick;

    // R-type slt
    op = R; funct = 6'b101010;
    tick; tick;
    at_neg; check("r_slt", {25'd0, state, alucontrol}, {25'd0, 4'd6, 3'b111});
    tick;
    at_neg; check("r_wb", {26'd0, state, regwrite, regdst}, {26'd0, 4'd7, 1'b1, 1'b1});
    tick;

    // beq taken / not taken
    op = BEQ; zero = 1'b1;
    tick; tick;
    at_neg; check("beq_taken", {22'd0, state, pcen, pcsrc, alucontrol},
                  {22'd0, 4'd8, 1'b1, 2'b01, 3'b110});
    tick;
    zero = 1'b0;
    tick; tick;
    at_neg; check("beq_not_taken", {27'd0, state, pcen}, {27'd0, 4'd8, 1'b0});
    tick;

    // j
    op = JMP;
    tick; tick;
    at_neg; check("j_jex", {25'd0, state, pcen, pcsrc}, {25'd0, 4'd11, 1'b1, 2'b10});
    tick;

    // illegal op: DECODE then straight back to FETCH
    op = 6'b111111;
    tick;
    at_neg; check("ill_decode", {28'd0, state}, 32'd1);
    tick;
    at_neg; check("ill_fetch", {26'd0, state, regwrite, memwrite}, {26'd0, 4'd0, 2'b00});

    // reset mid-lw in MEMRD
    op = LW;
    tick; tick; tick;
    reset = 1'b1;
    at_neg; check("midrst_hold", {27'd0, state, regwrite}, {27'd0, 4'd3, 1'b0});
    tick;
    reset = 1'b0;
    at_neg; check("midrst_fetch", {27'd0, state, regwrite}, {27'd0, 4'd0, 1'b0});

    // randomized instruction stream
    for (int i = 0; i < 4000; i++) begin
      if (m_pos == 0) begin
        case ($urandom_range(0, 6))
          0: op = R;
          1: op = LW;
          2: op = SW;
          3: op = BEQ;
          4: op = ADDI;
          5: op = JMP;
          default: op = 6'($urandom);
        endcase
        case ($urandom_range(0, 5))
          0: funct = 6'b100000;
          1: funct = 6'b100010;
          2: funct = 6'b100100;
          3: funct = 6'b100101;
          4: funct = 6'b101010;
          default: funct = 6'($urandom);
        endcase
      end
      zero  = 1'($urandom);
      reset = ($urandom_range(0, 39) == 0);
      tick;
    end
    reset = 1'b0;
    at_neg;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
